// File: rtl/alu_pkg.sv
// Purpose: widths, ALU op-select encodings and loader state type shared across the 12-bit ALU datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  // Datapath widths: operands are built from IN_W-bit beats; the op select
  // rides in the low SEL_W bits of a single beat.
  localparam int OP_W  = 12;
  localparam int IN_W  = 4;
  localparam int SEL_W = 4;

  // Operation select encodings decoded by the ALU result mux.
  typedef enum logic [SEL_W-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_LSHIFT = 4'd5,
    OP_RSHIFT = 4'd6
  } alu_op_e;

  // Operand loader frame sequencing.
  typedef enum logic [1:0] {
    S_LOAD_A   = 2'd0,
    S_LOAD_B   = 2'd1,
    S_LOAD_SEL = 2'd2,
    S_PRESENT  = 2'd3
  } loader_state_e;

  // Beat counter width for an N-beat operand; at least one bit so a
  // single-beat operand still has a legal (always-zero) counter.
  function automatic int cnt_width(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/nibble_shift_reg.sv
// Purpose: operand register filled MSB-beat first by shifting IN_W-bit beats in at the bottom.
// Latency: 1 cycle from load enable to updated q_o.
// Backpressure: none; shifts only when ld_en_i is high, otherwise holds.
module nibble_shift_reg #(
  parameter int W    = 12,
  parameter int IN_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            ld_en_i,
  input  logic [IN_W-1:0] din_i,
  output logic [W-1:0]    q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_shift;
  logic [W-1:0] q_d;

  // Shift-in value: older beats move toward the MSB end. A register only one
  // beat wide simply takes the beat.
  generate
    if (W > IN_W) begin : g_shift
      assign q_shift = {q_q[W-IN_W-1:0], din_i};
    end else begin : g_single
      assign q_shift = din_i;
    end
  endgenerate

  // Next-state: abort clears, a load shifts, otherwise hold the last contents.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (ld_en_i) begin
      q_d = q_shift;
    end
  end

  // Operand storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Purpose: assembles A, B (N beats each, MSB first) and op select from a nibble stream into a registered ALU frame.
// Latency: out_valid rises the cycle after the sel beat is accepted; in_ready returns the cycle after the handshake.
// Backpressure: in_ready is low while a frame is presented; the frame holds until out_ready is sampled high.
module alu_operand_loader #(
  parameter int OP_W  = alu_pkg::OP_W,
  parameter int IN_W  = alu_pkg::IN_W,
  parameter int SEL_W = alu_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic [SEL_W-1:0] op_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  import alu_pkg::*;

  // OP_W must be a multiple of IN_W and SEL_W must not exceed IN_W.
  localparam int N_BEATS = OP_W / IN_W;
  localparam int CNT_W   = cnt_width(N_BEATS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BEATS - 1);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic beat_acc;
  logic ld_a;
  logic ld_b;
  logic last_beat;

  // A beat lands only in a load state, so in_ready alone gates acceptance.
  assign beat_acc  = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_LAST);
  assign ld_a      = beat_acc && (state_q == S_LOAD_A);
  assign ld_b      = beat_acc && (state_q == S_LOAD_B);

  // Frame sequencing: next state, beat counter and the state-decoded handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q != S_PRESENT);
    out_valid = (state_q == S_PRESENT);
    if (clr) begin
      // Abort wins over any beat or handshake in the same cycle.
      state_d = S_LOAD_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD_A: begin
          if (beat_acc) begin
            if (last_beat) begin
              state_d = S_LOAD_B;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (beat_acc) begin
            if (last_beat) begin
              state_d = S_LOAD_SEL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LOAD_SEL: begin
          if (beat_acc) begin
            state_d = S_PRESENT;
            cnt_d   = '0;
          end
        end
        S_PRESENT: begin
          // No pass-through: loading restarts the cycle after the consumer takes the frame.
          if (out_ready) begin
            state_d = S_LOAD_A;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_LOAD_A;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Op select next value: low bits of the sel beat; upper bits of that beat are dropped.
  always_comb begin
    sel_d = sel_q;
    if (clr) begin
      sel_d = '0;
    end else if (beat_acc && (state_q == S_LOAD_SEL)) begin
      sel_d = in_data[SEL_W-1:0];
    end
  end

  // Op select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  nibble_shift_reg #(
    .W    (OP_W),
    .IN_W (IN_W)
  ) u_op_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .ld_en_i (ld_a),
    .din_i   (in_data),
    .q_o     (op_a)
  );

  nibble_shift_reg #(
    .W    (OP_W),
    .IN_W (IN_W)
  ) u_op_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .ld_en_i (ld_b),
    .din_i   (in_data),
    .q_o     (op_b)
  );

  assign op_sel = sel_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Purpose: self-checking bench for alu_operand_loader against a beat-counting frame model.
// Latency: checks outputs every falling edge; directed frames pin exact cycle timing.
// Backpressure: exercises held frames, gapped input, aborts, async reset and back-to-back streaming.
module tb_alu_operand_loader;

  localparam int OP_W  = 12;
  localparam int IN_W  = 4;
  localparam int SEL_W = 4;
  localparam int NB    = OP_W / IN_W;
  localparam int FRAME = 2 * NB + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             clr = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [SEL_W-1:0] op_sel;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  alu_operand_loader #(
    .OP_W  (OP_W),
    .IN_W  (IN_W),
    .SEL_W (SEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sel    (op_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is simply the next FRAME accepted beats; nothing is accepted
  // while a frame is being presented.
  logic [IN_W-1:0]  m_beats [FRAME];
  int               m_nb   = 0;
  bit               m_pres = 1'b0;
  logic [OP_W-1:0]  m_a    = '0;
  logic [OP_W-1:0]  m_b    = '0;
  logic [SEL_W-1:0] m_sel  = '0;

  function automatic logic [OP_W-1:0] compose(input int start);
    logic [OP_W-1:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v = (v << IN_W) | OP_W'(m_beats[start + i]);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nb   <= 0;
      m_pres <= 1'b0;
    end else if (clr) begin
      m_nb   <= 0;
      m_pres <= 1'b0;
    end else if (m_pres) begin
      if (out_ready) m_pres <= 1'b0;
    end else if (in_valid) begin
      if (m_nb == FRAME - 1) begin
        m_a    <= compose(0);
        m_b    <= compose(NB);
        m_sel  <= in_data[SEL_W-1:0];
        m_pres <= 1'b1;
        m_nb   <= 0;
      end else begin
        m_beats[m_nb] <= in_data;
        m_nb          <= m_nb + 1;
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  bit           chk_en = 1'b0;
  bit           sb_en  = 1'b0;
  int           hs_cnt = 0;
  logic [31:0]  exp_q [$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_pres));
      chk("out_valid", 32'(out_valid), 32'(m_pres));
      if (m_pres) begin
        chk("op_a", 32'(op_a), 32'(m_a));
        chk("op_b", 32'(op_b), 32'(m_b));
        chk("op_sel", 32'(op_sel), 32'(m_sel));
      end
      if (sb_en && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_frame: unexpected frame a=0x%0h b=0x%0h sel=0x%0h, expected none", op_a, op_b, op_sel);
        end else begin
          chk("sb_frame", {4'h0, op_a, op_b, op_sel}, exp_q.pop_front());
        end
        hs_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [IN_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  // Beats packed MSB-first: A nibbles, B nibbles, then sel.
  task automatic send_frame(input logic [27:0] f, input int gap);
    for (int i = 0; i < FRAME; i++) begin
      in_valid = 1'b1;
      in_data  = f[27 - 4*i -: 4];
      @(negedge clk);
      if (i < FRAME - 1 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                              input logic [SEL_W-1:0] s);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_op_a"}, 32'(op_a), 32'(a));
    chk({tag, "_op_b"}, 32'(op_b), 32'(b));
    chk({tag, "_op_sel"}, 32'(op_sel), 32'(s));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [IN_W-1:0] stream [$];
    int idx;
    int t;
    bit acc;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_sel", 32'(op_sel), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic frame, consecutive beats.
    out_ready = 1'b1;
    send_frame(28'hABC0035, 0);
    expect_frame("basic", 12'hABC, 12'h003, 4'h5);
    chk("basic_in_ready_present", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("basic_in_ready_after", 32'(in_ready), 32'd1);
    chk("basic_out_valid_after", 32'(out_valid), 32'd0);

    // Same frame with two idle cycles between beats.
    send_frame(28'hABC0035, 2);
    expect_frame("gap", 12'hABC, 12'h003, 4'h5);
    @(negedge clk);

    // Backpressure: frame held while the consumer stalls and the source pushes.
    out_ready = 1'b0;
    send_frame(28'hFFF0016, 0);
    in_valid = 1'b1;
    in_data  = 4'h7;
    for (int k = 0; k < 5; k++) begin
      expect_frame("bp", 12'hFFF, 12'h001, 4'h6);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(out_valid), 32'd0);
    send_frame(28'h8000003, 0);
    expect_frame("bp_next", 12'h800, 12'h000, 4'h3);
    @(negedge clk);

    // Abort mid-frame together with a valid beat.
    beat(4'h9); beat(4'h8); beat(4'h7); beat(4'h6);
    clr      = 1'b1;
    in_data  = 4'h5;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_op_a", 32'(op_a), 32'd0);
    chk("clr_op_b", 32'(op_b), 32'd0);
    chk("clr_op_sel", 32'(op_sel), 32'd0);
    send_frame(28'h1234562, 0);
    expect_frame("clr_next", 12'h123, 12'h456, 4'h2);
    @(negedge clk);

    // Asynchronous reset while loading B, between clock edges.
    beat(4'h9); beat(4'hA); beat(4'hB); beat(4'hC);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op_a", 32'(op_a), 32'd0);
    chk("arst_op_b", 32'(op_b), 32'd0);
    chk("arst_op_sel", 32'(op_sel), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(28'hDEF1235, 1);
    expect_frame("arst_next", 12'hDEF, 12'h123, 4'h5);
    @(negedge clk);

    // Random traffic: gaps, stalls and occasional aborts, checked by the model.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    clr      = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Back-to-back streaming: 100 random frames, one per 8 cycles.
    for (int k = 0; k < 100; k++) begin
      logic [OP_W-1:0]  a;
      logic [OP_W-1:0]  b;
      logic [SEL_W-1:0] s;
      a = 12'($urandom);
      b = 12'($urandom);
      s = 4'($urandom);
      stream.push_back(a[11:8]); stream.push_back(a[7:4]); stream.push_back(a[3:0]);
      stream.push_back(b[11:8]); stream.push_back(b[7:4]); stream.push_back(b[3:0]);
      stream.push_back(s);
      exp_q.push_back({4'h0, a, b, s});
    end
    out_ready = 1'b1;
    sb_en     = 1'b1;
    hs_cnt    = 0;
    idx       = 0;
    t         = 0;
    while (hs_cnt < 100 && t < 2000) begin
      if (idx < stream.size()) begin
        in_valid = 1'b1;
        in_data  = stream[idx];
        acc      = in_ready;
      end else begin
        in_valid = 1'b0;
        acc      = 1'b0;
      end
      @(negedge clk);
      #1;
      if (acc) idx++;
      t++;
    end
    in_valid = 1'b0;
    chk("b2b_frames", 32'(hs_cnt), 32'd100);
    chk("b2b_cycles", 32'(t), 32'd799);
    chk("b2b_beats", 32'(idx), 32'd700);
    chk("b2b_leftover", 32'(exp_q.size()), 32'd0);
    sb_en = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Upstream stage of the 12-bit ALU datapath (adder, shifters, logic units). It collects operands A and B and an operation select from a narrow nibble-wide input stream, such as board switches or a UART nibble decoder.
- Once the frame is complete, it presents registered, stable op_a, op_b and op_sel to the ALU with a valid/ready handshake.
- The ALU units stay purely combinational. This block supplies all the sequencing.

Parameters:
- OP_W, 12, operand width in bits; must be a multiple of IN_W
- IN_W, 4, input stream width in bits
- SEL_W, 4, operation-select width; must be <= IN_W (taken from the low bits of one beat)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous abort; discards the partial frame
- in_data  input  IN_W  stream beat
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a beat this cycle
- op_a  output  OP_W  operand A to the ALU
- op_b  output  OP_W  operand B to the ALU
- op_sel  output  SEL_W  ALU operation select
- out_valid  output  1  op_a/op_b/op_sel form a complete frame
- out_ready  input  1  ALU or result register consumes the frame

Behaviour:
- Frame format:
  - N = OP_W/IN_W beats for A, then N beats for B, then 1 beat for sel.
  - Default frame is 7 beats.
  - Operands arrive MSB nibble first.
- A beat is accepted when in_valid && in_ready on a rising edge.
- in_valid may drop between beats. Gaps never corrupt the frame.
- FSM states and transitions:
  - S_LOAD_A → S_LOAD_B after the N-th accepted beat.
  - S_LOAD_B → S_LOAD_SEL after the N-th accepted beat.
  - S_LOAD_SEL → S_PRESENT on the accepted beat.
  - S_PRESENT → S_LOAD_A when out_ready is sampled high.
- Beat counter: ceil(log2(N))-bit, cleared on each state change, increments on each accepted beat within S_LOAD_A/S_LOAD_B.
- Operand capture is shift-in: op_x <= {op_x[OP_W-IN_W-1:0], in_data}.
- op_sel <= in_data[SEL_W-1:0]. Upper bits of the sel beat are ignored.
- in_ready = 1 in the three load states and 0 in S_PRESENT. It is a pure decode of state.
- out_valid = 1 only in S_PRESENT. It asserts on the cycle after the sel beat is accepted (latency 1).
- While out_valid is high, op_a/op_b/op_sel are held constant until the handshake completes.
- Handshake completion: when out_valid && out_ready, the next state is S_LOAD_A. in_ready rises the following cycle, so there is no same-cycle pass-through.
- When out_valid is low, op_a/op_b contents are not meaningful to the consumer. They still hold the last shifted values; there is no zeroing between frames.
- out_ready while out_valid is low is ignored.
- clr:
  - Next state S_LOAD_A, counter 0.
  - op_a, op_b and op_sel are cleared to 0.
  - Takes priority over a simultaneous accepted beat or handshake.
  - clr in S_PRESENT drops out_valid the next cycle, and the frame is lost.
- Reset (rst_n low, at any time including mid-frame):
  - State S_LOAD_A, counter 0.
  - op_a = 0, op_b = 0, op_sel = 0, out_valid = 0.
  - in_ready = 1 after deassertion.
- Counter wrap: the counter never exceeds N-1. Reaching N-1 with an accepted beat forces the state change.

Decomposition:
- Shared package alu_pkg holds:
  - Widths OP_W = 12, IN_W = 4, SEL_W = 4.
  - Op-select encodings: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, LSHIFT = 5, RSHIFT = 6. The whole ALU mux uses these.
  - Loader state enum type.
- One sub-module is natural: nibble_shift_reg (parameterised width and load enable), instantiated twice for op_a and op_b.
- FSM and counter stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: beats A,B,C,0,0,3,5 on consecutive cycles with out_ready = 1.
  - Response: out_valid high exactly the cycle after the 7th beat, with op_a = 0xABC, op_b = 0x003, op_sel = 5.
  - in_ready is 0 that cycle and 1 the next cycle.
- Gapped input:
  - Stimulus: same 7 beats with in_valid low for 2 cycles between each beat.
  - Response: identical outputs; no extra beats captured.
- Backpressure:
  - Stimulus: complete frame F,F,F,0,0,1,6, then hold out_ready = 0 for 5 cycles while driving in_valid = 1 with data 7.
  - Response: out_valid stays high with op_a = 0xFFF, op_b = 0x001, op_sel = 6 throughout; in_ready = 0; beat 7 is not consumed.
- clr mid-frame:
  - Stimulus: send 4 beats, assert clr together with a 5th valid beat, then send a fresh frame 1,2,3,4,5,6,2.
  - Response: op_a = 0x123, op_b = 0x456, op_sel = 2; the 5th beat is discarded.
- Async reset mid-frame:
  - Stimulus: drop rst_n between clock edges in S_LOAD_B.
  - Response: out_valid and all operand outputs are 0 immediately, without waiting for a clock edge; after release a full frame loads correctly.
- Back-to-back frames:
  - Stimulus: out_ready held at 1 with continuous in_valid.
  - Response: one frame per 8 cycles (7 loads + 1 present), no beat lost or duplicated, checked by scoreboard over 100 random frames.
